button_debounce: RTL

// - Input-side counterpart of the LED counter demos: conditions CHANNELS raw push-button/switch pins into clean,

---
 rtl/button_debounce_pkg.sv | 31 +++
 rtl/button_debounce_channel.sv | 124 ++++++++++++
 rtl/button_debounce.sv | 45 ++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and cycle-count helpers for the push-button debouncer.
package button_debounce_pkg;

   localparam int unsigned HZ_PER_MHZ = 1_000_000;
   localparam int unsigned HZ_PER_KHZ = 1_000;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } db_state_e;

   // Per-channel conditioned outputs, all registered.
   typedef struct packed {
      logic pressed;
      logic press;
      logic rel;
      logic held;
      logic long_press;
   } btn_evt_t;

   function automatic int unsigned db_cycles(input int unsigned clk_hz, input int unsigned us);
      return clk_hz / HZ_PER_MHZ * us;
   endfunction

   function automatic int unsigned hold_cycles(input int unsigned clk_hz, input int unsigned ms);
      return clk_hz / HZ_PER_KHZ * ms;
   endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM, hold timer and event pulses.
module button_debounce_channel
   import button_debounce_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = 10,
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic     sysclk_i,
   input  logic     resetn_i,
   input  logic     btn_i,
   output btn_evt_t evt_o
);

   localparam int unsigned DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic              REL_LVL   = ACTIVE_LOW;

   logic [1:0]        sync_q, sync_d;
   db_state_e         state_q, state_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   btn_evt_t          evt_q, evt_d;
   logic              s_c;
   logic              hold_run_c;

   assign s_c   = sync_q[1] ^ ACTIVE_LOW;
   assign evt_o = evt_q;

   always_ff @(posedge sysclk_i) begin
      if (!resetn_i) begin
         sync_q     <= {2{REL_LVL}};
         state_q    <= ST_RELEASED;
         db_cnt_q   <= '0;
         hold_cnt_q <= '0;
         evt_q      <= '0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         db_cnt_q   <= db_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         evt_q      <= evt_d;
      end
   end

   always_comb begin
      sync_d           = {sync_q[0], btn_i};
      state_d          = state_q;
      db_cnt_d         = db_cnt_q;
      hold_cnt_d       = hold_cnt_q;
      evt_d            = evt_q;
      evt_d.press      = 1'b0;
      evt_d.rel        = 1'b0;
      evt_d.long_press = 1'b0;
      hold_run_c       = 1'b0;

      case (state_q)
         ST_RELEASED: begin
            if (s_c) begin
               state_d  = ST_PRESS_WAIT;
               db_cnt_d = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!s_c) begin
               state_d  = ST_RELEASED;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d       = ST_PRESSED;
               db_cnt_d      = '0;
               evt_d.pressed = 1'b1;
               evt_d.press   = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         ST_PRESSED: begin
            hold_run_c = 1'b1;
            if (!s_c) begin
               state_d  = ST_RELEASE_WAIT;
               db_cnt_d = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            if (s_c) begin
               state_d    = ST_PRESSED;
               db_cnt_d   = '0;
               hold_run_c = 1'b1;
            end else if (db_cnt_q == DB_LAST) begin
               state_d       = ST_RELEASED;
               db_cnt_d      = '0;
               hold_cnt_d    = '0;
               evt_d.pressed = 1'b0;
               evt_d.held    = 1'b0;
               evt_d.rel     = 1'b1;
            end else begin
               db_cnt_d   = db_cnt_q + 1'b1;
               hold_run_c = 1'b1;
            end
         end
         default: begin
            state_d    = ST_RELEASED;
            db_cnt_d   = '0;
            hold_cnt_d = '0;
            evt_d      = '0;
         end
      endcase

      // Hold timer saturates; held rises once per press, the edge after the count tops out.
      if (hold_run_c) begin
         if (hold_cnt_q == HOLD_LAST) begin
            if (!evt_q.held) begin
               evt_d.held       = 1'b1;
               evt_d.long_press = 1'b1;
            end
         end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_debounce.sv
// Debounces CHANNELS raw button pins into clean levels and press/release/long-press pulses.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int unsigned CHANNELS     = 8,
   parameter int unsigned SYS_CLK_FREQ = 30_000_000,
   parameter int unsigned DEBOUNCE_US  = 10_000,
   parameter int unsigned HOLD_MS      = 1_000,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic                sysclk_i,
   input  logic                resetn_i,
   input  logic [CHANNELS-1:0] btn_i,
   output logic [CHANNELS-1:0] pressed_o,
   output logic [CHANNELS-1:0] press_o,
   output logic [CHANNELS-1:0] release_o,
   output logic [CHANNELS-1:0] held_o,
   output logic [CHANNELS-1:0] long_press_o
);

   localparam int unsigned DB_CYCLES   = db_cycles(SYS_CLK_FREQ, DEBOUNCE_US);
   localparam int unsigned HOLD_CYCLES = hold_cycles(SYS_CLK_FREQ, HOLD_MS);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      btn_evt_t evt;

      button_debounce_channel #(
         .DB_CYCLES   (DB_CYCLES),
         .HOLD_CYCLES (HOLD_CYCLES),
         .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_channel (
         .sysclk_i (sysclk_i),
         .resetn_i (resetn_i),
         .btn_i    (btn_i[g]),
         .evt_o    (evt)
      );

      assign pressed_o[g]    = evt.pressed;
      assign press_o[g]      = evt.press;
      assign release_o[g]    = evt.rel;
      assign held_o[g]       = evt.held;
      assign long_press_o[g] = evt.long_press;
   end

endmodule
